traffic_sensor_conditioner: RTL and testbench

- Front-end stage directly upstream of traffic_light_controller.
- Turns raw, asynchronous, bouncy street-sensor contacts and the emergency request into clean `Sa`, `Sb` and `emergency` levels for the controller.
- Per-channel work: 2-FF synchronisation, debounce, and presence hold-over on street sensors.
- Emergency channel: minimum-assert / cooldown state machine, so the controller never sees glitches or sub-cycle pulses.

---
 rtl/traffic_pkg.sv | 19 +
 rtl/traffic_sensor_conditioner_if.sv | 38 +++
 rtl/sensor_debounce.sv | 56 +++++
 rtl/traffic_sensor_conditioner.sv | 162 ++++++++++++++++
 tb/tb_traffic_sensor_conditioner.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic intersection blocks: emergency FSM codes,
// light codes used by the controller and benches, and a small sizing helper.
package traffic_pkg;

    localparam logic [1:0] EMG_IDLE     = 2'd0;
    localparam logic [1:0] EMG_ACTIVE   = 2'd1;
    localparam logic [1:0] EMG_COOLDOWN = 2'd2;

    typedef enum logic [1:0] {
        LIGHT_R = 2'd0,
        LIGHT_Y = 2'd1,
        LIGHT_G = 2'd2
    } light_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// Raw-sensor / conditioned-level bundle between the street contacts and the controller.
// cnt_a/cnt_b and the CNT_W parameter exist only when TSC_CAR_COUNT_EN is defined.
interface traffic_sensor_conditioner_if
`ifdef TSC_CAR_COUNT_EN
    #(parameter int CNT_W = 8)
`endif
    ;

    logic raw_a;
    logic raw_b;
    logic raw_emg;
    logic Sa;
    logic Sb;
    logic emergency;
    logic emg_busy;
`ifdef TSC_CAR_COUNT_EN
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
`endif

    // The conditioner side: consumes raw contacts, drives clean levels.
    modport master (
        input  raw_a, raw_b, raw_emg,
        output Sa, Sb, emergency, emg_busy
`ifdef TSC_CAR_COUNT_EN
        , output cnt_a, cnt_b
`endif
    );

    modport slave (
        output raw_a, raw_b, raw_emg,
        input  Sa, Sb, emergency, emg_busy
`ifdef TSC_CAR_COUNT_EN
        , input cnt_a, cnt_b
`endif
    );

endinterface

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer for one contact.
// level_d_o is the level the debouncer will hold after the coming edge.
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic level_d_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive samples that disagree with the held level; flip on the last one.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (int'(cnt_q) == DEBOUNCE_CYCLES - 32'sd1) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchroniser and debounce state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o   = level_q;
    assign level_d_o = level_d;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions street sensors (debounce + presence hold-over) and the emergency request
// (minimum-assert / cooldown FSM). Arrival counters are built with TSC_CAR_COUNT_EN.
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 4,
    parameter int HOLD_CYCLES         = 8,
    parameter int EMG_MIN_CYCLES      = 16,
    parameter int EMG_COOLDOWN_CYCLES = 32
`ifdef TSC_CAR_COUNT_EN
    ,
    parameter int CNT_W               = 8
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    traffic_sensor_conditioner_if.master bus
);

    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int TW = $clog2(max2(EMG_MIN_CYCLES, EMG_COOLDOWN_CYCLES) + 1);

    logic [2:0]          deb_lvl_s;
    logic [2:0]          deb_nxt_s;
    logic [1:0]          pres_q;
    logic [1:0]          pres_d;
    logic [1:0][HW-1:0]  hold_q;
    logic [1:0][HW-1:0]  hold_d;
    logic [1:0]          emg_state_q;
    logic [1:0]          emg_state_d;
    logic [TW-1:0]       emg_t_q;
    logic [TW-1:0]       emg_t_d;
    logic                emg_out_q;
    logic                emg_out_d;
    logic                busy_q;
    logic                busy_d;
    logic                unused_s;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk(clk), .reset(reset), .raw_i(bus.raw_a),
        .level_o(deb_lvl_s[0]), .level_d_o(deb_nxt_s[0])
    );
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk(clk), .reset(reset), .raw_i(bus.raw_b),
        .level_o(deb_lvl_s[1]), .level_d_o(deb_nxt_s[1])
    );
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_e (
        .clk(clk), .reset(reset), .raw_i(bus.raw_emg),
        .level_o(deb_lvl_s[2]), .level_d_o(deb_nxt_s[2])
    );

    // Presence follows the next debounced level so Sa/Sb rise on the same edge as d.
    always_comb begin
        pres_d = '0;
        hold_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (deb_nxt_s[i]) begin
                pres_d[i] = 1'b1;
                hold_d[i] = HW'(HOLD_CYCLES);
            end else if (hold_q[i] != '0) begin
                pres_d[i] = 1'b1;
                hold_d[i] = hold_q[i] - HW'(1);
            end else begin
                pres_d[i] = 1'b0;
                hold_d[i] = '0;
            end
        end
    end

    // Emergency FSM on the registered debounced request; the unused code behaves as idle.
    always_comb begin
        emg_state_d = emg_state_q;
        emg_t_d     = emg_t_q;
        case (emg_state_q)
            EMG_ACTIVE: begin
                if (!deb_lvl_s[2] && (int'(emg_t_q) >= EMG_MIN_CYCLES - 32'sd1)) begin
                    emg_state_d = EMG_COOLDOWN;
                    emg_t_d     = '0;
                end else if (int'(emg_t_q) < EMG_MIN_CYCLES) begin
                    emg_t_d = emg_t_q + TW'(1);
                end else begin
                    emg_t_d = emg_t_q;
                end
            end
            EMG_COOLDOWN: begin
                if (int'(emg_t_q) >= EMG_COOLDOWN_CYCLES - 32'sd1) begin
                    emg_state_d = EMG_IDLE;
                    emg_t_d     = '0;
                end else begin
                    emg_t_d = emg_t_q + TW'(1);
                end
            end
            default: begin
                emg_t_d = '0;
                if (deb_lvl_s[2]) begin
                    emg_state_d = EMG_ACTIVE;
                end else begin
                    emg_state_d = EMG_IDLE;
                end
            end
        endcase
        emg_out_d = (emg_state_d == EMG_ACTIVE);
        busy_d    = (emg_state_d != EMG_IDLE);
    end

    // Hold-over and emergency state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pres_q      <= '0;
            hold_q      <= '0;
            emg_state_q <= EMG_IDLE;
            emg_t_q     <= '0;
            emg_out_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pres_q      <= pres_d;
            hold_q      <= hold_d;
            emg_state_q <= emg_state_d;
            emg_t_q     <= emg_t_d;
            emg_out_q   <= emg_out_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.Sa        = pres_q[0];
    assign bus.Sb        = pres_q[1];
    assign bus.emergency = emg_out_q;
    assign bus.emg_busy  = busy_q;

`ifdef TSC_CAR_COUNT_EN
    logic [1:0][CNT_W-1:0] cnt_q;
    logic [1:0][CNT_W-1:0] cnt_d;

    // Count debounced rising edges only; hold-over never counts.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (deb_nxt_s[i] && !deb_lvl_s[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Arrival counters, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.cnt_a = cnt_q[0];
    assign bus.cnt_b = cnt_q[1];
    assign unused_s  = deb_nxt_s[2];
`else
    assign unused_s  = ^{deb_nxt_s[2], deb_lvl_s[1:0]};
`endif

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: directed plan plus randomized contacts checked
// every cycle against a sample-window / timestamp model. Honours TSC_CAR_COUNT_EN.
module tb_traffic_sensor_conditioner;

    localparam int D     = 4;
    localparam int H     = 8;
    localparam int EMIN  = 16;
    localparam int ECOOL = 32;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   cmp_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

`ifdef TSC_CAR_COUNT_EN
    traffic_sensor_conditioner_if #(.CNT_W(CW)) bus ();
    traffic_sensor_conditioner #(
        .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .EMG_MIN_CYCLES(EMIN),
        .EMG_COOLDOWN_CYCLES(ECOOL), .CNT_W(CW)
    ) dut (.clk(clk), .reset(reset), .bus(bus));
`else
    traffic_sensor_conditioner_if bus ();
    traffic_sensor_conditioner #(
        .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .EMG_MIN_CYCLES(EMIN),
        .EMG_COOLDOWN_CYCLES(ECOOL)
    ) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    // ---------------- reference model ----------------
    // d flips when the last D synchronised samples (raw seen 2..D+1 edges ago) all
    // disagree with it; presence = d or d was high within the last H edges; the
    // emergency is tracked by phase start timestamps.
    int          n;
    logic [63:0] hist [3];
    logic        dm [3];
    int          last_high [2];
    int          phase, act_start, cool_start;
    int          exp_cnt [2];
    logic        exp_sa, exp_sb, exp_emg, exp_busy;

    always @(posedge clk) begin : model
        logic [2:0] raws;
        logic       e_prev;
        logic       all_diff;
        if (reset) begin
            n = 0;
            for (int c = 0; c < 3; c++) begin
                hist[c] = '0;
                dm[c]   = 1'b0;
            end
            for (int c = 0; c < 2; c++) begin
                last_high[c] = -100000;
                exp_cnt[c]   = 0;
            end
            phase = 0; act_start = 0; cool_start = 0;
            exp_sa = 1'b0; exp_sb = 1'b0; exp_emg = 1'b0; exp_busy = 1'b0;
        end else begin
            n++;
            raws   = {bus.raw_emg, bus.raw_b, bus.raw_a};
            e_prev = dm[2];
            for (int c = 0; c < 3; c++) begin
                hist[c] = {hist[c][62:0], raws[c]};
                all_diff = 1'b1;
                for (int k = 2; k <= D + 1; k++) begin
                    if (hist[c][k] == dm[c]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    dm[c] = ~dm[c];
                    if (c < 2 && dm[c] && exp_cnt[c] < CMAX) exp_cnt[c]++;
                end
            end
            for (int c = 0; c < 2; c++) begin
                if (dm[c]) last_high[c] = n;
            end
            exp_sa = dm[0] || ((n - last_high[0]) <= H);
            exp_sb = dm[1] || ((n - last_high[1]) <= H);
            if (phase == 0) begin
                if (e_prev) begin phase = 1; act_start = n; end
            end else if (phase == 1) begin
                if (!e_prev && (n - act_start) >= EMIN) begin phase = 2; cool_start = n; end
            end else begin
                if ((n - cool_start) >= ECOOL) phase = 0;
            end
            exp_emg  = (phase == 1);
            exp_busy = (phase != 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("Sa", 32'(bus.Sa), 32'(exp_sa));
            check("Sb", 32'(bus.Sb), 32'(exp_sb));
            check("emergency", 32'(bus.emergency), 32'(exp_emg));
            check("emg_busy", 32'(bus.emg_busy), 32'(exp_busy));
`ifdef TSC_CAR_COUNT_EN
            check("cnt_a", 32'(bus.cnt_a), 32'(exp_cnt[0]));
            check("cnt_b", 32'(bus.cnt_b), 32'(exp_cnt[1]));
`endif
        end
    end

    // ---------------- directed + random stimulus ----------------
    int emg_cnt, cool_cnt;
    bit sb_seen;

    task automatic step(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic run_count(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            if (bus.emergency) emg_cnt++;
            if (bus.emg_busy && !bus.emergency) cool_cnt++;
        end
    endtask

    initial begin
        int dur [3];
        bus.raw_a = 1'b0; bus.raw_b = 1'b0; bus.raw_emg = 1'b0;
        reset = 1'b1;
        step(3);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // 1: quiet after reset
        step(20);
        check("rst_Sa", 32'(bus.Sa), 32'd0);
        check("rst_Sb", 32'(bus.Sb), 32'd0);
        check("rst_emg", 32'(bus.emergency), 32'd0);
        check("rst_busy", 32'(bus.emg_busy), 32'd0);

        // 2: rise latency 6 edges, fall after debounce 6 + hold 8
        bus.raw_a = 1'b1;
        step(5);  check("a_rise_k5", 32'(bus.Sa), 32'd0);
        step(1);  check("a_rise_k6", 32'(bus.Sa), 32'd1);
        step(10);
        bus.raw_a = 1'b0;
        step(13); check("a_hold_m13", 32'(bus.Sa), 32'd1);
        step(1);  check("a_fall_m14", 32'(bus.Sa), 32'd0);

        // 3: bounce faster than the debounce window never reaches Sb
        sb_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.raw_b = ((i / 2) % 2 == 1) ? 1'b1 : 1'b0;
            step(1);
            if (bus.Sb) sb_seen = 1'b1;
        end
        bus.raw_b = 1'b0;
        step(10);
        check("b_bounce_seen", 32'(sb_seen), 32'd0);
`ifdef TSC_CAR_COUNT_EN
        check("b_bounce_cnt", 32'(bus.cnt_b), 32'd0);
`endif

        // 4: short pulse -> 16 active + 32 cooldown; pulse in cooldown ignored; later honoured
        emg_cnt = 0; cool_cnt = 0;
        bus.raw_emg = 1'b1; run_count(6);
        bus.raw_emg = 1'b0; run_count(24);
        bus.raw_emg = 1'b1; run_count(6);
        bus.raw_emg = 1'b0; run_count(34);
        check("emg_first_active", 32'(emg_cnt), 32'd16);
        check("emg_first_cool", 32'(cool_cnt), 32'd32);
        check("emg_idle_again", 32'(bus.emg_busy), 32'd0);
        bus.raw_emg = 1'b1; run_count(6);
        bus.raw_emg = 1'b0; run_count(60);
        check("emg_total_active", 32'(emg_cnt), 32'd32);
        check("emg_total_cool", 32'(cool_cnt), 32'd64);

        // 5: long request holds emergency until 6 edges after release
        bus.raw_emg = 1'b1;
        step(100);
        bus.raw_emg = 1'b0;
        step(6);  check("emg_long_r6", 32'(bus.emergency), 32'd1);
        step(1);  check("emg_long_r7", 32'(bus.emergency), 32'd0);
        check("emg_long_busy", 32'(bus.emg_busy), 32'd1);
        step(40);

        // random contacts with a reset in the middle
        for (int c = 0; c < 3; c++) dur[c] = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                reset = 1'b1; step(2); reset = 1'b0;
            end
            if (dur[0] == 0) begin bus.raw_a   = 1'($urandom_range(0, 1)); dur[0] = $urandom_range(1, 14); end
            if (dur[1] == 0) begin bus.raw_b   = 1'($urandom_range(0, 1)); dur[1] = $urandom_range(1, 14); end
            if (dur[2] == 0) begin bus.raw_emg = 1'($urandom_range(0, 1)); dur[2] = $urandom_range(1, 40); end
            for (int c = 0; c < 3; c++) dur[c]--;
            step(1);
        end
        bus.raw_a = 1'b0; bus.raw_b = 1'b0; bus.raw_emg = 1'b0;
        step(60);

        // 6: clean pulses drive the counter to saturation, then async reset mid-pulse
`ifdef TSC_CAR_COUNT_EN
        for (int p = 0; p < 300; p++) begin
`else
        for (int p = 0; p < 5; p++) begin
`endif
            bus.raw_a = 1'b1; step(10);
            bus.raw_a = 1'b0; step(20);
        end
`ifdef TSC_CAR_COUNT_EN
        check("cnt_a_sat", 32'(bus.cnt_a), 32'd255);
`endif
        bus.raw_a = 1'b1;
        step(8);
        check("a_pre_reset", 32'(bus.Sa), 32'd1);
        #2 reset = 1'b1;
        #1 check("a_async_reset", 32'(bus.Sa), 32'd0);
`ifdef TSC_CAR_COUNT_EN
        check("cnt_a_async_reset", 32'(bus.cnt_a), 32'd0);
`endif
        bus.raw_a = 1'b0;
        step(2);
        reset = 1'b0;
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
